// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: loads/stores via a req/ack data-memory port, stalling upstream while in flight.
// Optional REQ-state ack watchdog is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       aluresult_in,
  input  logic [15:0]       op2_in,
  input  logic [15:0]       instrin,
  input  logic              isld,
  input  logic              isst,
  input  logic              iswb,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       result_out,
  output logic [15:0]       instrout,
  output logic              iswb_out,
  output logic              isld_out,
  output logic              mem_err,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_alu;
  logic [15:0] r_wdata;
  logic [15:0] r_instr;
  logic [15:0] r_rdata;
  logic        r_we;
  logic        r_iswb;
  logic        r_isld;
  logic        r_abort;

  logic [15:0] r_result;
  logic [15:0] r_instr_out;
  logic        r_iswb_out;
  logic        r_isld_out;
  logic        r_err;

  logic        w_is_mem;
  logic        w_timeout;

  assign w_is_mem = isld | isst;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts REQ cycles already spent without ack; the limit hits in the cycle the count would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_REQ) && !mem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  // Watchdog disabled: the limit has no effect and REQ waits for ack indefinitely.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_is_mem) w_next = S_REQ;
      S_REQ:   if (mem_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gated by reset so every output reads 0 while reset is asserted, whatever upstream presents.
  assign stall   = reset & (((r_state == S_IDLE) & w_is_mem) | (r_state == S_REQ));
  assign mem_req = (r_state == S_REQ);

  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_alu[ADDR_W-1:0] : '0;
  assign mem_wdata = mem_req ? r_wdata : 16'h0;

  // Access context is captured once on the IDLE->REQ edge and held until the access retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu   <= '0;
      r_wdata <= '0;
      r_instr <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_iswb  <= 1'b0;
      r_isld  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_alu   <= aluresult_in;
            r_wdata <= op2_in;
            r_instr <= instrin;
            r_we    <= isst & ~isld;
            r_iswb  <= iswb;
            r_isld  <= isld;
            r_abort <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ack && !r_we) r_rdata <= mem_rdata;
          if (w_timeout)        r_abort <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Writeback register: bubbles whenever stall is high, the retired memory op on the DONE edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result    <= '0;
      r_instr_out <= '0;
      r_iswb_out  <= 1'b0;
      r_isld_out  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_result    <= '0;
            r_instr_out <= '0;
            r_iswb_out  <= 1'b0;
            r_isld_out  <= 1'b0;
          end else begin
            r_result    <= aluresult_in;
            r_instr_out <= instrin;
            r_iswb_out  <= iswb;
            r_isld_out  <= 1'b0;
          end
        end
        S_DONE: begin
          r_instr_out <= r_instr;
          if (r_abort) begin
            r_result   <= '0;
            r_iswb_out <= 1'b0;
            r_isld_out <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_result   <= r_isld ? r_rdata : r_alu;
            r_iswb_out <= r_iswb;
            r_isld_out <= r_isld;
          end
        end
        default: begin
          r_result    <= '0;
          r_instr_out <= '0;
          r_iswb_out  <= 1'b0;
          r_isld_out  <= 1'b0;
        end
      endcase
    end
  end

  assign result_out  = r_result;
  assign instrout    = r_instr_out;
  assign iswb_out    = r_iswb_out;
  assign isld_out    = r_isld_out;
  assign mem_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, load, store, back-to-back, reset abort and ack watchdog.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [15:0] aluresult_in;
  logic [15:0] op2_in;
  logic [15:0] instrin;
  logic        isld;
  logic        isst;
  logic        iswb;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] result_out;
  logic [15:0] instrout;
  logic        iswb_out;
  logic        isld_out;
  logic        mem_err;
  logic [1:0]  o_dbg_state;

  int n_checks;
  int n_pass;
  int stall_cnt;

  mem_access_stage #(.ADDR_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .aluresult_in(aluresult_in), .op2_in(op2_in), .instrin(instrin),
    .isld(isld), .isst(isst), .iswb(iswb),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .result_out(result_out), .instrout(instrout), .iswb_out(iswb_out), .isld_out(isld_out),
    .mem_err(mem_err), .o_dbg_state(o_dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver
  task automatic drive(input logic [15:0] ins, input logic [15:0] alu, input logic [15:0] op2,
                       input logic ld, input logic st, input logic wb);
    instrin      = ins;
    aluresult_in = alu;
    op2_in       = op2;
    isld         = ld;
    isst         = st;
    iswb         = wb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    n_checks++; if ({result_out, instrout, iswb_out, isld_out} !== 34'h0)
      $display("FAIL reset_outs: got %h required 0", {result_out, instrout, iswb_out, isld_out}); else n_pass++;
    n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall} !== 28'h0)
      $display("FAIL reset_mem: got %h required 0", {mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall}); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL reset_state: got %0d required 0", o_dbg_state); else n_pass++;
  endtask

  task automatic test_passthrough();
    drive(16'h1234, 16'h0042, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL pt_stall: got %b required 0", stall); else n_pass++;
    @(negedge clk);
    n_checks++; if (result_out !== 16'h0042) $display("FAIL pt_result: got %h required 0042", result_out); else n_pass++;
    n_checks++; if (instrout !== 16'h1234) $display("FAIL pt_instr: got %h required 1234", instrout); else n_pass++;
    n_checks++; if ({iswb_out, isld_out} !== 2'b10) $display("FAIL pt_flags: got %b required 10", {iswb_out, isld_out}); else n_pass++;
    drive(16'h5678, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1;
    #1;
    n_checks++; if ({stall, mem_req} !== 2'b00) $display("FAIL pt_ack_ignored: got %b required 00", {stall, mem_req}); else n_pass++;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({result_out, instrout, iswb_out} !== {16'hFFFF, 16'h5678, 1'b0})
      $display("FAIL pt_vec2: got %h/%h/%b required ffff/5678/0", result_out, instrout, iswb_out); else n_pass++;
    n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL pt_state: got %0d required 0", o_dbg_state); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_load();
    drive(16'h4001, 16'h0105, 16'h0, 1'b1, 1'b0, 1'b1);
    stall_cnt = 0;
    #1;
    n_checks++; if ({stall, mem_req} !== 2'b10) $display("FAIL ld_idle: got %b required 10", {stall, mem_req}); else n_pass++;
    if (stall) stall_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h05})
        $display("FAIL ld_req%0d: got req=%b we=%b addr=%h required 1/0/05", i, mem_req, mem_we, mem_addr); else n_pass++;
      n_checks++; if ({instrout, iswb_out} !== 17'h0) $display("FAIL ld_bubble%0d: got %h required 0", i, instrout); else n_pass++;
      if (stall) stall_cnt++;
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    n_checks++; if ({stall, mem_req, o_dbg_state} !== 4'b0010)
      $display("FAIL ld_done: got stall=%b req=%b st=%0d required 0/0/2", stall, mem_req, o_dbg_state); else n_pass++;
    if (stall) stall_cnt++;
    n_checks++; if (stall_cnt !== 4) $display("FAIL ld_stall_len: got %0d required 4", stall_cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if ({result_out, instrout, iswb_out, isld_out} !== {16'hBEEF, 16'h4001, 2'b11})
      $display("FAIL ld_retire: got %h/%h/%b/%b required beef/4001/1/1", result_out, instrout, iswb_out, isld_out); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (instrout !== 16'h0) $display("FAIL ld_single: got %h required 0", instrout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(16'h5002, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL st_stall: got %b required 1", stall); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h10, 16'hA5A5})
      $display("FAIL st_req: got req=%b we=%b addr=%h wd=%h required 1/1/10/a5a5", mem_req, mem_we, mem_addr, mem_wdata); else n_pass++;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++; if ({stall, instrout} !== 17'h0) $display("FAIL st_done: got stall=%b instr=%h required 0/0", stall, instrout); else n_pass++;
    @(negedge clk);
    n_checks++; if ({result_out, instrout, iswb_out, isld_out} !== {16'h0010, 16'h5002, 2'b00})
      $display("FAIL st_retire: got %h/%h/%b/%b required 0010/5002/0/0", result_out, instrout, iswb_out, isld_out); else n_pass++;
    drive(16'h2222, 16'h0077, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    n_checks++; if ({stall, mem_req} !== 2'b00) $display("FAIL b2b_stall: got %b required 00", {stall, mem_req}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({result_out, instrout, iswb_out} !== {16'h0077, 16'h2222, 1'b1})
      $display("FAIL b2b_alu: got %h/%h/%b required 0077/2222/1", result_out, instrout, iswb_out); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (instrout !== 16'h0) $display("FAIL b2b_nodup: got %h required 0", instrout); else n_pass++;
  endtask

  task automatic test_ld_st_both();
    drive(16'h6003, 16'h0033, 16'h1111, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h33})
      $display("FAIL both_req: got req=%b we=%b addr=%h required 1/0/33", mem_req, mem_we, mem_addr); else n_pass++;
    mem_ack = 1'b1; mem_rdata = 16'h0C0C;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    n_checks++; if ({result_out, instrout, isld_out} !== {16'h0C0C, 16'h6003, 1'b1})
      $display("FAIL both_retire: got %h/%h/%b required 0c0c/6003/1", result_out, instrout, isld_out); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(16'h7004, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_pre: got %b required 1", mem_req); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({mem_req, stall, mem_addr, o_dbg_state} !== 12'h0)
      $display("FAIL rst_mid: got req=%b stall=%b addr=%h st=%0d required 0", mem_req, stall, mem_addr, o_dbg_state); else n_pass++;
    @(negedge clk);
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({o_dbg_state, mem_req, instrout} !== 19'h0)
      $display("FAIL rst_after: got st=%0d req=%b instr=%h required 0", o_dbg_state, mem_req, instrout); else n_pass++;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    drive(16'h8005, 16'h0044, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if ({mem_req, mem_err} !== 2'b10) $display("FAIL tmo_req%0d: got %b required 10", i, {mem_req, mem_err}); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if ({mem_req, mem_err, o_dbg_state} !== 4'b0010) $display("FAIL tmo_done: got %b required 0010", {mem_req, mem_err, o_dbg_state}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({mem_err, result_out, iswb_out, instrout} !== {1'b1, 16'h0, 1'b0, 16'h8005})
      $display("FAIL tmo_abort: got err=%b res=%h wb=%b instr=%h required 1/0000/0/8005", mem_err, result_out, iswb_out, instrout); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (mem_err !== 1'b0) $display("FAIL tmo_pulse: got %b required 0", mem_err); else n_pass++;
  endtask

  task automatic test_ack_at_limit();
    drive(16'h9006, 16'h0045, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) begin mem_ack = 1'b1; mem_rdata = 16'h1234; end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    n_checks++; if ({mem_err, result_out, iswb_out, isld_out} !== {1'b0, 16'h1234, 2'b11})
      $display("FAIL lim_ack: got err=%b res=%h wb=%b ld=%b required 0/1234/1/1", mem_err, result_out, iswb_out, isld_out); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    drive(16'hA007, 16'h0046, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++; if ({mem_req, mem_err} !== 2'b10) $display("FAIL wait_req%0d: got %b required 10", i, {mem_req, mem_err}); else n_pass++;
      if (i == 20) begin mem_ack = 1'b1; mem_rdata = 16'hCAFE; end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    n_checks++; if ({mem_err, result_out, instrout} !== {1'b0, 16'hCAFE, 16'hA007})
      $display("FAIL wait_retire: got err=%b res=%h instr=%h required 0/cafe/a007", mem_err, result_out, instrout); else n_pass++;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_passthrough();
    test_load();
    test_back_to_back();
    test_ld_st_both();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
    test_ack_at_limit();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
